attack_check_display: RTL and testbench

- Per-player helper block for the Battleship datapath. It combines two functions.
- Move checker (combinational): validates that a player's new 16-bit attack pattern adds exactly one new square to the previously accepted pattern. Its ok flag drives the load enable of the previous-attack register.
- Status display (sequential): drives a 4-digit multiplexed seven-segment display with one of two fixed 4-letter words, chosen by a select bit.

---
 rtl/attack_check_display_pkg.sv | 42 ++++
 rtl/attack_check_display_seg_word_scanner.sv | 36 +++
 rtl/attack_check_display.sv | 38 +++
 tb/tb_attack_check_display.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/attack_check_display_pkg.sv
// Shared constants for the Battleship per-player helper: seven-segment glyphs
// (active-low, {dp,g,f,e,d,c,b,a}) and the blanked digit-enable pattern.
package attack_check_display_pkg;

  localparam logic [7:0] GLYPH_P     = 8'h8C;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_Y     = 8'h91;
  localparam logic [7:0] GLYPH_O     = 8'hC0;
  localparam logic [7:0] GLYPH_S     = 8'h92;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF      = 4'b1111;

  typedef enum logic {
    WORD_PLAY = 1'b0,
    WORD_LOSE = 1'b1
  } word_e;

  // Digit 3 is the leftmost letter, digit 0 the rightmost.
  function automatic logic [7:0] word_glyph(input word_e sel, input logic [1:0] d);
    logic [7:0] g;
    g = GLYPH_BLANK;
    if (sel == WORD_PLAY) begin
      case (d)
        2'd3: g = GLYPH_P;
        2'd2: g = GLYPH_L;
        2'd1: g = GLYPH_A;
        default: g = GLYPH_Y;
      endcase
    end else begin
      case (d)
        2'd3: g = GLYPH_L;
        2'd2: g = GLYPH_O;
        2'd1: g = GLYPH_S;
        default: g = GLYPH_E;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/attack_check_display_seg_word_scanner.sv
// Multiplexed 4-digit seven-segment scanner showing one of two fixed words.
// The top two bits of a free-running counter pick the digit being lit.
module seg_word_scanner
  import attack_check_display_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       word_sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       d;
  word_e            sel;

  assign d   = cnt[CNT_W-1 -: 2];
  assign sel = word_e'(word_sel);

  // Outputs are decoded from the pre-increment count so the first edge after
  // reset lights digit 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      an  <= AN_OFF;
      seg <= GLYPH_BLANK;
    end else begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      an  <= ~(4'b0001 << d);
      seg <= word_glyph(sel, d);
    end
  end

endmodule

// File: rtl/attack_check_display.sv
// Per-player helper: combinational single-square attack checker plus the
// PLAY/LOSE status scanner for the seven-segment display.
module attack_check_display
  import attack_check_display_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 18
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] prev,
  input  logic [N-1:0] curr,
  output logic         ok,
  output logic [N-1:0] new_mask,
  input  logic         word_sel,
  output logic [7:0]   seg,
  output logic [3:0]   an
);

  logic [N-1:0] lost;
  logic         one_new;

  assign new_mask = curr & ~prev;
  assign lost     = prev & ~curr;
  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
  assign one_new  = (new_mask != '0) &&
                    ((new_mask & (new_mask - {{(N-1){1'b0}}, 1'b1})) == '0);
  assign ok       = (lost == '0) && one_new;

  seg_word_scanner #(.CNT_W(CNT_W)) u_scan (
    .clk      (clk),
    .clr_n    (clr_n),
    .word_sel (word_sel),
    .seg      (seg),
    .an       (an)
  );

endmodule

// File: tb/tb_attack_check_display.sv
// Bench for attack_check_display: table-driven checker vectors and a
// scoreboarded display scan with reset, word-switch and mid-scan reset cases.
module tb_attack_check_display;

  localparam int N     = 16;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [N-1:0] prev, curr;
  logic         ok;
  logic [N-1:0] new_mask;
  logic         word_sel;
  logic [7:0]   seg;
  logic [3:0]   an;

  int passed = 0;
  int total  = 0;

  attack_check_display #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .prev     (prev),
    .curr     (curr),
    .ok       (ok),
    .new_mask (new_mask),
    .word_sel (word_sel),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] prev;
    logic [N-1:0] curr;
    logic         ok;
    logic [N-1:0] mask;
  } chk_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } disp_t;

  disp_t sb_q[$];

  // Expected glyphs indexed by digit (0 = rightmost letter).
  logic [7:0] play_g [4];
  logic [7:0] lose_g [4];
  logic [3:0] an_for [4];
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock edge: push the expected registered outputs, then compare after the edge.
  task automatic step(input string name);
    disp_t e, a;
    logic [1:0] d;
    d     = m_cnt[CNT_W-1 -: 2];
    e.an  = an_for[d];
    e.seg = word_sel ? lose_g[d] : play_g[d];
    sb_q.push_back(e);
    @(posedge clk);
    m_cnt = m_cnt + 1'b1;
    #1;
    a = sb_q.pop_front();
    check({name, ".an"},  {28'h0, an},  {28'h0, a.an});
    check({name, ".seg"}, {24'h0, seg}, {24'h0, a.seg});
  endtask

  initial begin
    chk_vec_t vecs [8];
    logic [3:0] an_before;
    int guard;

    play_g = '{8'h91, 8'h88, 8'hC7, 8'h8C};
    lose_g = '{8'h86, 8'h92, 8'hC0, 8'hC7};
    an_for = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    vecs[0] = '{16'h0000, 16'h0010, 1'b1, 16'h0010};
    vecs[1] = '{16'h0010, 16'h8010, 1'b1, 16'h8000};
    vecs[2] = '{16'h00F0, 16'h00F0, 1'b0, 16'h0000};
    vecs[3] = '{16'h00F0, 16'h03F0, 1'b0, 16'h0300};
    vecs[4] = '{16'h00F0, 16'h01E0, 1'b0, 16'h0100};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000};
    vecs[7] = '{16'h0001, 16'h0000, 1'b0, 16'h0000};

    clr_n = 1'b0; word_sel = 1'b0; prev = '0; curr = '0; m_cnt = '0;

    // Checker: table vectors then single-bit sweep.
    for (int i = 0; i < 8; i++) begin
      prev = vecs[i].prev; curr = vecs[i].curr;
      #1;
      check($sformatf("vec%0d.ok", i),   {31'h0, ok},       {31'h0, vecs[i].ok});
      check($sformatf("vec%0d.mask", i), {16'h0, new_mask}, {16'h0, vecs[i].mask});
    end
    prev = '0;
    for (int i = 0; i < N; i++) begin
      curr = 16'h0001 << i;
      #1;
      check($sformatf("sweep%0d.ok", i), {31'h0, ok}, 32'h1);
    end

    // Reset held across edges keeps the display blank.
    @(posedge clk); @(posedge clk); #1;
    check("rst.an",  {28'h0, an},  32'hF);
    check("rst.seg", {24'h0, seg}, 32'hFF);

    clr_n = 1'b1;
    for (int i = 1; i <= 17; i++) step($sformatf("play_e%0d", i));

    word_sel = 1'b1;
    for (int i = 0; i < 16; i++) step($sformatf("lose_%0d", i));

    // Mid-digit toggle: seg follows word_sel on the next edge, an holds.
    while (m_cnt[1:0] != 2'd1) step("align");
    an_before = an;
    word_sel = 1'b0;
    step("toggle");
    check("toggle.an_hold", {28'h0, an}, {28'h0, an_before});

    // Async reset mid-scan while digit 2 is lit.
    guard = 0;
    while (an !== 4'b1011 && guard < 20) begin
      step("seek");
      guard++;
    end
    check("seek.found", {28'h0, an}, 32'hB);
    #2;
    clr_n = 1'b0;
    #1;
    check("async.an",  {28'h0, an},  32'hF);
    check("async.seg", {24'h0, seg}, 32'hFF);
    @(posedge clk); #1;
    clr_n = 1'b1;
    m_cnt = '0;
    for (int i = 0; i < 5; i++) step($sformatf("restart%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
